// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: IDLE/RUN/PAUSE control, sub-second prescaler and
// a 4-digit BCD MM:SS count that wraps 59:59 -> 00:00 with a one-clk overflow pulse.
// Optional lap/display-hold feature is built when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_core #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned PRE_W         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       overflow,
  output logic       disp_held
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam logic [PRE_W-1:0] PreMax = PRE_W'(TICKS_PER_SEC - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       min_tens_q, min_tens_d;
  logic [3:0]       min_ones_q, min_ones_d;
  logic [2:0]       sec_tens_q, sec_tens_d;
  logic [3:0]       sec_ones_q, sec_ones_d;
  logic             ovf_q, ovf_d;
  logic             advance;

  // State, prescaler, digits and overflow pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state: FSM transitions, prescaler counting and the BCD carry chain.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    ovf_d      = 1'b0;
    advance    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Count is already zero here, so clear has nothing to do.
        if (start_stop) state_d = StRun;
      end
      StRun: begin
        // A tick coincident with start_stop is still counted before pausing.
        if (tick) begin
          if (pre_q == PreMax) begin
            pre_d   = '0;
            advance = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        if (start_stop) state_d = StPause;
      end
      StPause: begin
        // clear has priority over start_stop when both arrive together.
        if (clear) begin
          state_d    = StIdle;
          pre_d      = '0;
          min_tens_d = '0;
          min_ones_d = '0;
          sec_tens_d = '0;
          sec_ones_d = '0;
        end else if (start_stop) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q == 3'd5) begin
          sec_tens_d = 3'd0;
          if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            if (min_tens_q == 3'd5) begin
              min_tens_d = 3'd0;
              ovf_d      = 1'b1;
            end else begin
              min_tens_d = min_tens_q + 3'd1;
            end
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 3'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end
  end

  assign running  = (state_q == StRun);
  assign overflow = ovf_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       held_q, held_d;
  logic [2:0] hold_min_tens_q, hold_min_tens_d;
  logic [3:0] hold_min_ones_q, hold_min_ones_d;
  logic [2:0] hold_sec_tens_q, hold_sec_tens_d;
  logic [3:0] hold_sec_ones_q, hold_sec_ones_d;

  // Display-hold flag and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q          <= 1'b0;
      hold_min_tens_q <= '0;
      hold_min_ones_q <= '0;
      hold_sec_tens_q <= '0;
      hold_sec_ones_q <= '0;
    end else begin
      held_q          <= held_d;
      hold_min_tens_q <= hold_min_tens_d;
      hold_min_ones_q <= hold_min_ones_d;
      hold_sec_tens_q <= hold_sec_tens_d;
      hold_sec_ones_q <= hold_sec_ones_d;
    end
  end

  // Lap toggles the hold in RUN; pausing or an accepted clear always releases it.
  always_comb begin
    held_d          = held_q;
    hold_min_tens_d = hold_min_tens_q;
    hold_min_ones_d = hold_min_ones_q;
    hold_sec_tens_d = hold_sec_tens_q;
    hold_sec_ones_d = hold_sec_ones_q;
    if (state_q == StRun) begin
      if (start_stop) begin
        held_d = 1'b0;
      end else if (lap) begin
        if (held_q) begin
          held_d = 1'b0;
        end else begin
          // Snapshot the count as currently displayed, before this cycle's tick.
          held_d          = 1'b1;
          hold_min_tens_d = min_tens_q;
          hold_min_ones_d = min_ones_q;
          hold_sec_tens_d = sec_tens_q;
          hold_sec_ones_d = sec_ones_q;
        end
      end
    end else if (state_q == StPause && clear) begin
      held_d = 1'b0;
    end
  end

  assign disp_held = held_q;
  assign min_tens  = held_q ? hold_min_tens_q : min_tens_q;
  assign min_ones  = held_q ? hold_min_ones_q : min_ones_q;
  assign sec_tens  = held_q ? hold_sec_tens_q : sec_tens_q;
  assign sec_ones  = held_q ? hold_sec_ones_q : sec_ones_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp_held  = 1'b0;
  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at TICKS_PER_SEC=4: elapsed-tick reference model compared
// every cycle, plus directed sequences with hand-computed MM:SS expectations.
module tb_stopwatch_core;
  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [2:0] min_tens, sec_tens;
  logic [3:0] min_ones, sec_ones;
  logic       running, overflow, disp_held;

  int checks = 0;
  int failures = 0;
  int ovf_total = 0;

  stopwatch_core #(.TICKS_PER_SEC(TPS), .PRE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
    .lap(lap), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .running(running), .overflow(overflow), .disp_held(disp_held)
  );

  always #5 clk = ~clk;

  // Reference model: state 0=idle 1=run 2=pause, count kept as elapsed ticks.
  typedef struct {
    int st;
    int ticks;
    bit ovf;
    bit held;
    int hold_secs;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t c, bit t, bit ss, bit cl, bit lp);
    model_t n = c;
    n.ovf = 1'b0;
    case (c.st)
      0: if (ss) n.st = 1;
      1: begin
        if (t) begin
          n.ticks = c.ticks + 1;
          if (n.ticks == 3600 * TPS) begin
            n.ticks = 0;
            n.ovf   = 1'b1;
          end
        end
        if (ss) begin
          n.st   = 2;
          n.held = 1'b0;
        end
`ifdef STOPWATCH_LAP_HOLD_EN
        else if (lp) begin
          if (c.held) n.held = 1'b0;
          else begin
            n.held      = 1'b1;
            n.hold_secs = c.ticks / TPS;
          end
        end
`else
        else if (lp) n.held = 1'b0;
`endif
      end
      default: begin
        if (cl) begin
          n.st    = 0;
          n.ticks = 0;
          n.held  = 1'b0;
        end else if (ss) n.st = 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [16:0] expected(model_t c);
    int secs, mm, ss;
    secs = c.held ? c.hold_secs : c.ticks / TPS;
    mm = secs / 60;
    ss = secs % 60;
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), c.st == 1, c.ovf, c.held};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic check_time(string name, int mm, int ss);
    check(name, {17'd0, min_tens, min_ones, sec_tens, sec_ones},
          {17'd0, 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)});
  endtask

  // Model advances on the same edges as the DUT, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 1'b0, 1'b0, 0};
    else m <= model_step(m, tick, start_stop, clear, lap);
  end

  // Compare all outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("outputs", {15'd0, min_tens, min_ones, sec_tens, sec_ones, running, overflow,
            disp_held}, {15'd0, expected(m)});
      if (overflow) ovf_total++;
    end
  end

  task automatic step(bit t, bit ss, bit cl, bit lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic do_ticks(int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    // 1. Reset
    #12;
    check_time("reset_digits", 0, 0);
    check("reset_flags", {29'd0, running, overflow, disp_held}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_time("after_reset", 0, 0);

    // 2. Start and count a minute
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("running_after_start", {31'd0, running}, 32'd1);
    do_ticks(236);
    check_time("t236", 0, 59);
    do_ticks(4);
    check_time("t240", 1, 0);
    check("running_t240", {31'd0, running}, 32'd1);

    // 3. Pause retains prescaler; ticks in pause ignored
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("cleared", 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    do_ticks(6);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    do_ticks(10);
    check_time("paused_1s", 0, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    do_ticks(2);
    check_time("resume_2s", 0, 2);

    // 4. Wrap at 59:59
    base = ovf_total;
    do_ticks(14391);
    check_time("t5959", 59, 59);
    do_ticks(1);
    check_time("wrap", 0, 0);
    check("ovf_pulse", {30'd0, overflow, running}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_drop", {31'd0, overflow}, 32'd0);
    check("ovf_count", ovf_total - base, 32'd1);
    do_ticks(12);
    check_time("after_wrap", 0, 3);

    // 5. clear ignored in RUN; clear beats start_stop in PAUSE
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("clear_in_run", 0, 3);
    check("run_after_clear", {31'd0, running}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_time("clear_ss", 0, 0);
    check("idle_after_clear", {31'd0, running}, 32'd0);

`ifdef STOPWATCH_LAP_HOLD_EN
    // 6. Lap hold
    step(1'b0, 1'b1, 1'b0, 1'b0);
    do_ticks(20);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    do_ticks(8);
    check_time("lap_held", 0, 5);
    check("disp_held_1", {31'd0, disp_held}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("lap_release", 0, 7);
    check("disp_held_0", {31'd0, disp_held}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`else
    // 6. lap has no effect
    step(1'b0, 1'b1, 1'b0, 1'b0);
    do_ticks(20);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    do_ticks(8);
    check_time("lap_ignored", 0, 7);
    check("disp_held_tied", {31'd0, disp_held}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic, including occasional asynchronous reset
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #2;
        check_time("async_reset", 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
